// File: rtl/latch_output_monitor.sv
// Synchronises a gated latch's complementary outputs, counts value toggles and flags a sticky complement fault.
// Latency: q_sync lags qa by SYNC_STAGES edges; no backpressure (inputs are sampled every cycle).
module latch_output_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8,
  parameter int MISMATCH_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qa,
  input  logic             qb,
  input  logic             clear,
  output logic             q_sync,
  output logic             mismatch,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             fault,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_OK    = 2'd1,
    ST_MISM  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [3:0]       LIMIT     = 4'(MISMATCH_LIMIT);
  localparam logic [1:0]       FILL_LAST = 2'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] qa_sync_q, qa_sync_d;
  logic [SYNC_STAGES-1:0] qb_sync_q, qb_sync_d;
  logic [1:0]             fill_q, fill_d;
  logic [3:0]             run_q, run_d;
  logic [CNT_W-1:0]       toggle_cnt_q, toggle_cnt_d;
  logic [CNT_W-1:0]       fault_cnt_q, fault_cnt_d;
  logic                   fault_q, fault_d;

  logic qa_s;
  logic qb_s;
  logic q_next;
  logic fault_enter;

  always_comb begin
    qa_sync_d = {qa_sync_q[SYNC_STAGES-2:0], qa};
    qb_sync_d = {qb_sync_q[SYNC_STAGES-2:0], qb};
  end

  assign qa_s   = qa_sync_q[SYNC_STAGES-1];
  assign qb_s   = qb_sync_q[SYNC_STAGES-1];
  // Value q_sync will take on the coming edge, used to detect a toggle on that edge.
  assign q_next = qa_sync_q[SYNC_STAGES-2];

  assign mismatch = (state_q != ST_WAIT) && (qa_s == qb_s);

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    run_d        = run_q;
    fault_d      = fault_q;
    fault_cnt_d  = fault_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    fault_enter  = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (fill_q == FILL_LAST) begin
          state_d = ST_OK;
          fill_d  = 2'd0;
        end else begin
          fill_d = fill_q + 2'd1;
        end
      end
      ST_OK: begin
        if (mismatch) begin
          if (LIMIT == 4'd1) begin
            state_d     = ST_FAULT;
            fault_enter = 1'b1;
          end else begin
            state_d = ST_MISM;
          end
          run_d = 4'd1;
        end
      end
      ST_MISM: begin
        if (!mismatch) begin
          state_d = ST_OK;
          run_d   = 4'd0;
        end else begin
          run_d = run_q + 4'd1;
          if (run_q + 4'd1 == LIMIT) begin
            state_d     = ST_FAULT;
            fault_enter = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (state_q != ST_WAIT && q_next != qa_s && toggle_cnt_q != CNT_MAX) begin
      toggle_cnt_d = toggle_cnt_q + CNT_ONE;
    end

    if (fault_enter) begin
      fault_d = 1'b1;
      if (fault_cnt_q != CNT_MAX) begin
        fault_cnt_d = fault_cnt_q + CNT_ONE;
      end
    end

    // Clear overrides everything above, but the WAIT fill count runs on untouched.
    if (clear) begin
      toggle_cnt_d = '0;
      fault_cnt_d  = '0;
      fault_d      = 1'b0;
      run_d        = 4'd0;
      if (state_q != ST_WAIT) begin
        state_d = ST_OK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT;
      qa_sync_q    <= '0;
      qb_sync_q    <= '0;
      fill_q       <= 2'd0;
      run_q        <= 4'd0;
      toggle_cnt_q <= '0;
      fault_cnt_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      qa_sync_q    <= qa_sync_d;
      qb_sync_q    <= qb_sync_d;
      fill_q       <= fill_d;
      run_q        <= run_d;
      toggle_cnt_q <= toggle_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
      fault_q      <= fault_d;
    end
  end

  assign q_sync     = qa_s;
  assign toggle_cnt = toggle_cnt_q;
  assign fault_cnt  = fault_cnt_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule
